// File: rtl/relock_controller.sv
// Lock-acquisition controller: hysteresis/debounce lock detect, triangle relock sweep,
// PID gating, status flags and a saturating relock-event counter.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_UNLOCKED | no lock; sweep runs, PID disabled, waiting for trans >= thr_hi
// ST_SETTLING | transmission acquired; PID on, sweep frozen, hold timer running
// ST_LOCKED   | settled lock (or forced by relock_en_in=0); PID on, sweep frozen
module relock_controller #(
  parameter int W           = 16,
  parameter int DWELL_W     = 32,
  parameter int DEBOUNCE    = 4,
  parameter int HOLD_CYCLES = 100000000,
  parameter int CNT_W       = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                relock_en_in,
  input  logic signed [W-1:0] trans_in,
  input  logic signed [W-1:0] thr_lo_in,
  input  logic signed [W-1:0] thr_hi_in,
  input  logic signed [W-1:0] sweep_min_in,
  input  logic signed [W-1:0] sweep_max_in,
  input  logic [DWELL_W-1:0]  dwell_in,
  output logic signed [W-1:0] sweep_out,
  output logic                pid_on_out,
  output logic                locked_out,
  output logic                unlocked_out,
  output logic                settling_out,
  output logic [CNT_W-1:0]    relock_cnt_out
);

  localparam int DEB_W  = $clog2(DEBOUNCE + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE);
  localparam logic [DEB_W-1:0]  DEB_ARM   = DEB_W'(DEBOUNCE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic signed [W-1:0] ONE     = 1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SETTLING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 below_q;
  logic                 above_q;
  logic [DEB_W-1:0]     deb_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic                 dir_up;

  logic                 unlock_ev;
  logic                 hold_done;
  logic                 degenerate;
  logic                 step_due;
  logic [DWELL_W-1:0]   dwell_m1;
  logic signed [W-1:0]  step_val;
  logic                 step_dir_up;

  // unlock fires on the edge where the debounce count would reach DEBOUNCE
  always_comb begin
    unlock_ev = below_q && (deb_cnt >= DEB_ARM) && (state_q != ST_UNLOCKED);
    hold_done = (hold_cnt == HOLD_LAST);

    state_d = state_q;
    if (!relock_en_in) begin
      state_d = ST_LOCKED;
    end else begin
      case (state_q)
        ST_UNLOCKED: if (above_q) state_d = ST_SETTLING;
        ST_SETTLING: begin
          if (unlock_ev)      state_d = ST_UNLOCKED;
          else if (hold_done) state_d = ST_LOCKED;
        end
        ST_LOCKED:   if (unlock_ev) state_d = ST_UNLOCKED;
        default:     state_d = ST_UNLOCKED;
      endcase
    end
  end

  // A step that lands on a limit turns the sweep around, so the limit value is
  // shown for exactly one dwell period.
  always_comb begin
    degenerate = (sweep_min_in >= sweep_max_in);
    dwell_m1   = (dwell_in == '0) ? '0 : dwell_in - 1'b1;
    step_due   = (dwell_cnt >= dwell_m1);

    if (dir_up)
      step_val = (sweep_out < sweep_max_in) ? sweep_out + ONE : sweep_out - ONE;
    else
      step_val = (sweep_out > sweep_min_in) ? sweep_out - ONE : sweep_out + ONE;

    if (step_val >= sweep_max_in)      step_dir_up = 1'b0;
    else if (step_val <= sweep_min_in) step_dir_up = 1'b1;
    else                               step_dir_up = (step_val > sweep_out);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_UNLOCKED;
      below_q        <= 1'b0;
      above_q        <= 1'b0;
      deb_cnt        <= '0;
      hold_cnt       <= '0;
      dwell_cnt      <= '0;
      dir_up         <= 1'b1;
      sweep_out      <= '0;
      relock_cnt_out <= '0;
      pid_on_out     <= 1'b0;
      locked_out     <= 1'b0;
      unlocked_out   <= 1'b1;
      settling_out   <= 1'b0;
    end else begin
      below_q <= (trans_in < thr_lo_in);
      above_q <= (trans_in >= thr_hi_in);

      state_q      <= state_d;
      pid_on_out   <= (state_d != ST_UNLOCKED);
      locked_out   <= (state_d == ST_LOCKED);
      unlocked_out <= (state_d == ST_UNLOCKED);
      settling_out <= (state_d == ST_SETTLING);

      if (!relock_en_in || state_q == ST_UNLOCKED || !below_q)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX)
        deb_cnt <= deb_cnt + 1'b1;

      if (!relock_en_in || state_q != ST_SETTLING)
        hold_cnt <= '0;
      else if (!unlock_ev && !hold_done)
        hold_cnt <= hold_cnt + 1'b1;

      if (relock_en_in && state_q == ST_UNLOCKED && above_q && relock_cnt_out != '1)
        relock_cnt_out <= relock_cnt_out + 1'b1;

      // dwell counter and direction persist outside UNLOCKED so the sweep resumes in place
      if (relock_en_in && state_q == ST_UNLOCKED) begin
        if (degenerate) begin
          sweep_out <= sweep_min_in;
        end else if (sweep_out > sweep_max_in) begin
          sweep_out <= sweep_max_in;
          dir_up    <= 1'b0;
          dwell_cnt <= '0;
        end else if (sweep_out < sweep_min_in) begin
          sweep_out <= sweep_min_in;
          dir_up    <= 1'b1;
          dwell_cnt <= '0;
        end else if (step_due) begin
          sweep_out <= step_val;
          dir_up    <= step_dir_up;
          dwell_cnt <= '0;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_relock_controller.sv
// Randomised scoreboard bench for relock_controller: a behavioural model predicts every
// cycle's outputs, which a separate monitor compares against the DUT.
module tb_relock_controller;

  localparam int DEB  = 4;
  localparam int HOLD = 100;
  localparam int CMAX = 3;
  localparam int M_UNL = 0;
  localparam int M_SET = 1;
  localparam int M_LCK = 2;

  typedef struct packed {
    logic signed [15:0] sweep;
    logic               pid;
    logic               lck;
    logic               unl;
    logic               set;
    logic [1:0]         cnt;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               relock_en = 1'b1;
  logic signed [15:0] trans = '0;
  logic signed [15:0] thr_lo = '0;
  logic signed [15:0] thr_hi = '0;
  logic signed [15:0] sweep_min = '0;
  logic signed [15:0] sweep_max = '0;
  logic [31:0]        dwell = '0;
  logic signed [15:0] sweep_out;
  logic               pid_on_out, locked_out, unlocked_out, settling_out;
  logic [1:0]         relock_cnt_out;

  relock_controller #(
    .W(16), .DWELL_W(32), .DEBOUNCE(DEB), .HOLD_CYCLES(HOLD), .CNT_W(2)
  ) dut (
    .clk_in(clk), .rst_in(rst), .relock_en_in(relock_en), .trans_in(trans),
    .thr_lo_in(thr_lo), .thr_hi_in(thr_hi), .sweep_min_in(sweep_min),
    .sweep_max_in(sweep_max), .dwell_in(dwell), .sweep_out(sweep_out),
    .pid_on_out(pid_on_out), .locked_out(locked_out), .unlocked_out(unlocked_out),
    .settling_out(settling_out), .relock_cnt_out(relock_cnt_out)
  );

  initial forever #5 clk = ~clk;

  // stimulus settings, applied to the DUT at each falling edge
  bit cfg_rst = 1'b1;
  bit cfg_en  = 1'b1;
  int cfg_trans = -1000, cfg_lo = 5000, cfg_hi = 8000;
  int cfg_min = -100, cfg_max = 100, cfg_dw = 3;

  // model: lock status, consecutive-below run, time in settling, sweep position/heading
  int m_st, m_run, m_age, m_cnt, m_pos, m_dir, m_dwell;
  bit m_pb, m_pa;

  exp_t q[$];
  bit   done = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  task automatic sweep_model();
    int per;
    if (cfg_min >= cfg_max) begin
      m_pos = cfg_min;
    end else if (m_pos > cfg_max) begin
      m_pos = cfg_max; m_dir = -1; m_dwell = 0;
    end else if (m_pos < cfg_min) begin
      m_pos = cfg_min; m_dir = 1; m_dwell = 0;
    end else begin
      per = (cfg_dw == 0) ? 1 : cfg_dw;
      m_dwell++;
      if (m_dwell >= per) begin
        m_dwell = 0;
        if (m_pos + m_dir > cfg_max || m_pos + m_dir < cfg_min) m_dir = -m_dir;
        m_pos += m_dir;
        if (m_pos == cfg_max)      m_dir = -1;
        else if (m_pos == cfg_min) m_dir = 1;
      end
    end
  endtask

  task automatic model_step();
    bit   unlock;
    exp_t e;
    if (cfg_rst) begin
      m_st = M_UNL; m_pos = 0; m_dir = 1; m_dwell = 0;
      m_run = 0; m_age = 0; m_cnt = 0; m_pb = 0; m_pa = 0;
    end else begin
      if (cfg_en && m_st == M_UNL) sweep_model();
      if (m_st == M_UNL || !m_pb || !cfg_en) m_run = 0;
      else if (m_run < DEB) m_run++;
      unlock = (m_st != M_UNL) && (m_run >= DEB);
      if (!cfg_en) begin
        m_st = M_LCK; m_age = 0;
      end else begin
        case (m_st)
          M_UNL: if (m_pa) begin
            m_st = M_SET; m_age = 0;
            if (m_cnt < CMAX) m_cnt++;
          end
          M_SET: if (unlock) m_st = M_UNL;
                 else begin
                   m_age++;
                   if (m_age >= HOLD) m_st = M_LCK;
                 end
          default: if (unlock) m_st = M_UNL;
        endcase
      end
      m_pb = (cfg_trans < cfg_lo);
      m_pa = (cfg_trans >= cfg_hi);
    end
    e.sweep = m_pos[15:0];
    e.pid   = (m_st != M_UNL);
    e.lck   = (m_st == M_LCK);
    e.unl   = (m_st == M_UNL);
    e.set   = (m_st == M_SET);
    e.cnt   = m_cnt[1:0];
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = cfg_rst;
      relock_en = cfg_en;
      trans     = cfg_trans[15:0];
      thr_lo    = cfg_lo[15:0];
      thr_hi    = cfg_hi[15:0];
      sweep_min = cfg_min[15:0];
      sweep_max = cfg_max[15:0];
      dwell     = cfg_dw;
      model_step();
    end
  endtask

  initial begin
    int guard, thold, calm;
    cyc(3);
    cfg_rst = 0;
    cyc(700);
    // acquire, settle, lock
    cfg_trans = 9000;
    cyc(110);
    // short dip must not unlock, long dip must
    cfg_trans = 4000; cyc(3);
    cfg_trans = 6000; cyc(2);
    cfg_trans = 4000; cyc(8);
    cfg_trans = -1000; cyc(20);
    // unlock lands on the same edge the hold would complete
    cfg_trans = 9000;
    guard = 0;
    do begin cyc(1); guard++; end while (m_st != M_SET && guard < 50);
    cyc(HOLD - DEB - 1);
    cfg_trans = 4000; cyc(10);
    cfg_trans = -1000; cyc(5);
    // limit clamp and degenerate range
    cfg_dw = 1;
    guard = 0;
    do begin cyc(1); guard++; end while (!(m_pos == 50 && m_st == M_UNL) && guard < 1000);
    cfg_max = 20; cyc(5);
    cfg_min = 30; cfg_max = 30; cyc(10);
    cfg_min = -100; cfg_max = 100; cfg_dw = 2; cyc(50);
    // manual mode forces lock
    cfg_en = 0; cyc(10);
    cfg_en = 1; cyc(30);
    // reset mid-sweep, then saturate the relock counter
    cfg_rst = 1; cyc(1);
    cfg_rst = 0; cyc(20);
    repeat (5) begin
      cfg_trans = 9000; cyc(3);
      cfg_trans = 4000; cyc(8);
    end
    cfg_trans = -1000; cyc(10);
    // randomised operation
    thold = 0; calm = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) calm = ($urandom_range(0, 2) != 0);
      if (thold == 0) begin
        if (calm != 0) begin
          if ($urandom_range(0, 9) == 0) begin
            cfg_trans = int'($urandom_range(0, 6999)) - 2000;
            thold = int'($urandom_range(1, 3));
          end else begin
            cfg_trans = 5000 + int'($urandom_range(0, 7000));
            thold = int'($urandom_range(1, 8));
          end
        end else begin
          cfg_trans = int'($urandom_range(0, 12000)) - 2000;
          thold = int'($urandom_range(1, 12));
        end
      end
      thold--;
      if (i % 150 == 0) begin
        cfg_min = -int'($urandom_range(0, 200));
        cfg_max = int'($urandom_range(0, 250)) - 50;
        cfg_dw  = int'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 299) == 0) cfg_en = !cfg_en;
      cfg_rst = ($urandom_range(0, 1499) == 0);
      cyc(1);
    end
    cfg_rst = 0;
    cfg_en = 1;
    cyc(2);
    done = 1'b1;
  end

  initial begin
    exp_t e, a;
    int   ncyc;
    ncyc = 0;
    forever begin
      @(posedge clk);
      #1;
      ncyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {sweep_out, pid_on_out, locked_out, unlocked_out, settling_out, relock_cnt_out};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL outputs cyc %0d: got sweep=%0d pid=%b lck=%b unl=%b set=%b cnt=%0d, want sweep=%0d pid=%b lck=%b unl=%b set=%b cnt=%0d",
                   ncyc, $signed(a.sweep), a.pid, a.lck, a.unl, a.set, a.cnt,
                   $signed(e.sweep), e.pid, e.lck, e.unl, e.set, e.cnt);
        end
      end else if (done) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end
      if (ncyc > 60000) begin
        mismatched++;
        $display("FAIL watchdog: got %0d cycles without completion, want <= 60000", ncyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end
    end
  end

endmodule
